// File: rtl/enigma_pkg.sv
// Shared PS/2 receiver definitions: scan-code prefixes, frame FSM states and
// the frame parity helper.
package enigma_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam int         PS2_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // PS/2 uses odd parity over the 8 data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus stability filter for one PS/2 line; idles at 1.
// The output level flips only after FILTER_LEN consecutive samples disagree with it.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_level
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             w_differs;

    assign w_differs = (r_sync[1] != r_level);
    assign o_level   = r_level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_line};
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: filters the raw lines, deframes 11-bit frames and
// folds E0/F0 prefixes into the ext/make flags of the following scan code.
module ps2_keyboard_receiver
    import enigma_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_ready,
    output logic       make,
    output logic       ext,
    output logic [7:0] key_input,
    output logic       frame_error
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic w_clk_f;
    logic w_data_f;
    logic w_fall;
    logic w_tmo_hit;
    logic w_frame_ok;

    logic r_clk_prev;
    ps2_state_t r_state;
    ps2_state_t w_state_next;

    logic [7:0]       r_shift;
    logic [2:0]       r_bitcnt;
    logic             r_parity;
    logic [TMO_W-1:0] r_tmo;
    logic             r_ext_pend;
    logic             r_brk_pend;

    logic       r_key_ready;
    logic       r_frame_error;
    logic       r_make;
    logic       r_ext;
    logic [7:0] r_key;

    logic w_start;
    logic w_shift_en;
    logic w_par_en;
    logic w_frame_end;
    logic w_timeout;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .reset   (reset),
        .i_line  (ps2_clk),
        .o_level (w_clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .reset   (reset),
        .i_line  (ps2_data),
        .o_level (w_data_f)
    );

    assign w_fall     = r_clk_prev & ~w_clk_f;
    assign w_tmo_hit  = (r_tmo >= TMO_LAST);
    assign w_frame_ok = w_data_f & odd_parity_ok(r_shift, r_parity);

    assign key_ready   = r_key_ready;
    assign frame_error = r_frame_error;
    assign make        = r_make;
    assign ext         = r_ext;
    assign key_input   = r_key;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_clk_prev <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_clk_prev <= w_clk_f;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift_en   = 1'b0;
        w_par_en     = 1'b0;
        w_frame_end  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall && !w_data_f) begin
                    w_state_next = DATA;
                    w_start      = 1'b1;
                end
            end
            DATA: begin
                if (w_fall) begin
                    w_shift_en = 1'b1;
                    if (r_bitcnt == 3'(PS2_DATA_BITS - 1)) begin
                        w_state_next = PARITY;
                    end
                end else if (w_tmo_hit) begin
                    w_state_next = IDLE;
                    w_timeout    = 1'b1;
                end
            end
            PARITY: begin
                if (w_fall) begin
                    w_par_en     = 1'b1;
                    w_state_next = STOP;
                end else if (w_tmo_hit) begin
                    w_state_next = IDLE;
                    w_timeout    = 1'b1;
                end
            end
            STOP: begin
                if (w_fall) begin
                    w_frame_end  = 1'b1;
                    w_state_next = IDLE;
                end else if (w_tmo_hit) begin
                    w_state_next = IDLE;
                    w_timeout    = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Inter-edge watchdog: zero while idle or on a fall, saturating otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo <= '0;
        end else if (r_state == IDLE || w_fall || w_timeout) begin
            r_tmo <= '0;
        end else if (r_tmo != TMO_MAX) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift       <= '0;
            r_bitcnt      <= '0;
            r_parity      <= 1'b0;
            r_ext_pend    <= 1'b0;
            r_brk_pend    <= 1'b0;
            r_key_ready   <= 1'b0;
            r_frame_error <= 1'b0;
            r_make        <= 1'b0;
            r_ext         <= 1'b0;
            r_key         <= '0;
        end else begin
            r_key_ready   <= 1'b0;
            r_frame_error <= 1'b0;
            if (w_start) begin
                r_shift  <= '0;
                r_bitcnt <= '0;
            end
            if (w_shift_en) begin
                r_shift  <= {w_data_f, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_par_en) begin
                r_parity <= w_data_f;
            end
            if (w_frame_end) begin
                if (!w_frame_ok) begin
                    r_frame_error <= 1'b1;
                    r_ext_pend    <= 1'b0;
                    r_brk_pend    <= 1'b0;
                end else if (r_shift == PS2_PREFIX_EXT) begin
                    r_ext_pend <= 1'b1;
                end else if (r_shift == PS2_PREFIX_BRK) begin
                    r_brk_pend <= 1'b1;
                end else begin
                    r_key_ready <= 1'b1;
                    r_key       <= r_shift;
                    r_ext       <= r_ext_pend;
                    r_make      <= ~r_brk_pend;
                    r_ext_pend  <= 1'b0;
                    r_brk_pend  <= 1'b0;
                end
            end
            if (w_timeout) begin
                r_frame_error <= 1'b1;
                r_ext_pend    <= 1'b0;
                r_brk_pend    <= 1'b0;
                r_shift       <= '0;
                r_bitcnt      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Scoreboard bench for ps2_keyboard_receiver: frames are bit-banged on the PS/2
// lines, expected strobes come from a byte-level prefix model.
module tb_ps2_keyboard_receiver;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int HALF           = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_ready;
    logic       make;
    logic       ext;
    logic [7:0] key_input;
    logic       frame_error;

    always #5 clk = ~clk;

    ps2_keyboard_receiver #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_ready   (key_ready),
        .make        (make),
        .ext         (ext),
        .key_input   (key_input),
        .frame_error (frame_error)
    );

    typedef struct packed {
        logic       err;
        logic [7:0] key;
        logic       mk;
        logic       ex;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic       m_ext_pend = 1'b0;
    logic       m_brk_pend = 1'b0;
    logic [7:0] m_key = 8'h00;
    logic       m_make = 1'b0;
    logic       m_ext = 1'b0;

    // Monitor: every strobe cycle consumes one expected event.
    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (reset && (key_ready || frame_error)) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe: key_ready=%0b frame_error=%0b key=%02h, no event expected",
                         key_ready, frame_error, key_input);
            end else begin
                e = sb_q.pop_front();
                if (e.err) ok = frame_error && !key_ready;
                else ok = key_ready && !frame_error && key_input == e.key && make == e.mk && ext == e.ex;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL strobe: got kr=%0b fe=%0b key=%02h make=%0b ext=%0b, expected err=%0b key=%02h make=%0b ext=%0b",
                             key_ready, frame_error, key_input, make, ext, e.err, e.key, e.mk, e.ex);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic good_par(input logic [7:0] b);
        return ~(^b);
    endfunction

    // Byte-level model of what the keyboard stream means.
    task automatic predict(input logic [7:0] b, input logic par, input logic stop);
        exp_t e;
        if (!(stop && ($countones({b, par}) % 2 == 1))) begin
            e = '{err: 1'b1, key: 8'h00, mk: 1'b0, ex: 1'b0};
            sb_q.push_back(e);
            m_ext_pend = 1'b0;
            m_brk_pend = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext_pend = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk_pend = 1'b1;
        end else begin
            m_key  = b;
            m_make = !m_brk_pend;
            m_ext  = m_ext_pend;
            e = '{err: 1'b0, key: b, mk: m_make, ex: m_ext};
            sb_q.push_back(e);
            m_ext_pend = 1'b0;
            m_brk_pend = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic check_settled(input string name);
        n_cmp++;
        if (sb_q.size() != 0 || key_input != m_key || make != m_make || ext != m_ext) begin
            n_bad++;
            $display("FAIL %s: pending=%0d key=%02h make=%0b ext=%0b, required pending=0 key=%02h make=%0b ext=%0b",
                     name, sb_q.size(), key_input, make, ext, m_key, m_make, m_ext);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input string name);
        predict(b, par, stop);
        send_bits({stop, par, b, 1'b0}, 11);
        tick(60);
        check_settled(name);
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if (key_ready !== 1'b0 || frame_error !== 1'b0 || make !== 1'b0 ||
            ext !== 1'b0 || key_input !== 8'h00) begin
            n_bad++;
            $display("FAIL %s: kr=%0b fe=%0b make=%0b ext=%0b key=%02h, required all zero",
                     name, key_ready, frame_error, make, ext, key_input);
        end
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit expired, pending=%0d", sb_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        logic       par;
        logic       stop;
        int         r;

        tick(5);
        check_reset_outputs("reset_state");
        reset = 1'b1;
        tick(10);

        send_frame(8'h1C, good_par(8'h1C), 1'b1, "make_1C");

        send_frame(8'hF0, good_par(8'hF0), 1'b1, "brk_prefix");
        send_frame(8'h1C, good_par(8'h1C), 1'b1, "break_1C");

        send_frame(8'hE0, good_par(8'hE0), 1'b1, "ext_prefix");
        send_frame(8'hF0, good_par(8'hF0), 1'b1, "ext_brk_prefix");
        send_frame(8'h75, good_par(8'h75), 1'b1, "ext_break_75");
        send_frame(8'h1C, good_par(8'h1C), 1'b1, "after_ext_1C");

        send_frame(8'h1C, ~good_par(8'h1C), 1'b1, "bad_parity");
        send_frame(8'hF0, good_par(8'hF0), 1'b1, "brk_before_err");
        send_frame(8'h33, ~good_par(8'h33), 1'b1, "bad_parity2");
        send_frame(8'h1C, good_par(8'h1C), 1'b1, "make_after_err");
        send_frame(8'h1C, good_par(8'h1C), 1'b0, "bad_stop");

        // Truncated frame left to time out.
        predict(8'h00, 1'b0, 1'b0);
        send_bits({2'b11, 8'b0000_1011, 1'b0}, 5);
        tick(TIMEOUT_CYCLES + 10);
        check_settled("timeout");
        send_frame(8'h1C, good_par(8'h1C), 1'b1, "after_timeout");

        // Reset in the middle of a frame, with a break prefix pending.
        send_frame(8'hF0, good_par(8'hF0), 1'b1, "brk_before_reset");
        send_bits({2'b11, 8'b0001_0101, 1'b0}, 6);
        reset = 1'b0;
        tick(3);
        check_reset_outputs("reset_midframe");
        m_ext_pend = 1'b0;
        m_brk_pend = 1'b0;
        m_key = 8'h00;
        m_make = 1'b0;
        m_ext = 1'b0;
        reset = 1'b1;
        tick(10);
        check_settled("after_reset_quiet");
        send_frame(8'h2A, good_par(8'h2A), 1'b1, "after_reset_2A");

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r < 2) b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else b = 8'($urandom_range(0, 255));
            par  = good_par(b) ^ ($urandom_range(0, 9) == 0);
            stop = ($urandom_range(0, 14) != 0);
            send_frame(b, par, stop, "random_frame");
        end

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL final_queue: %0d events outstanding, required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
